// File: rtl/mux_scan_serializer_if.sv
// Bus between a 16:1 mux scan serializer and its surroundings: word handshake,
// mux drive/return, and the sampled bit and reassembled word outputs.
interface mux_scan_serializer_if;
    logic        in_valid;
    logic [15:0] din;
    logic        in_ready;
    logic [15:0] D;
    logic [3:0]  sel;
    logic        mux_out;
    logic        bit_out;
    logic        bit_valid;
    logic [15:0] cap_word;
    logic        done;

    modport master (
        output in_valid, din, mux_out,
        input  in_ready, D, sel, bit_out, bit_valid, cap_word, done
    );

    modport slave (
        input  in_valid, din, mux_out,
        output in_ready, D, sel, bit_out, bit_valid, cap_word, done
    );
endinterface

// File: rtl/mux_scan_serializer.sv
// Scans a registered 16-bit word through an external 16:1 mux one index at a time
// and rebuilds it from the mux samples. Define SCAN_DIR_DOWN_EN to scan 15 down to 0.
module mux_scan_serializer #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_scan_serializer_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

`ifdef SCAN_DIR_DOWN_EN
    localparam logic [3:0] FIRST_IDX = 4'd15;
    localparam logic [3:0] LAST_IDX  = 4'd0;
`else
    localparam logic [3:0] FIRST_IDX = 4'd0;
    localparam logic [3:0] LAST_IDX  = 4'd15;
`endif

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] word_q, word_d;
    logic [3:0]  sel_q, sel_d;
    logic [7:0]  hold_q, hold_d;
    logic        bit_out_q, bit_out_d;
    logic        bit_valid_q, bit_valid_d;
    logic        done_q, done_d;
    logic [15:0] cap_q, cap_d;

    logic        accept;
    logic        sample_en;
    logic [3:0]  sel_step;
    logic [15:0] sel_hit;

    assign accept    = (state_q == ST_IDLE) && bus.in_valid;
    assign sample_en = (state_q == ST_SCAN) && (hold_q == HOLD_LAST);

`ifdef SCAN_DIR_DOWN_EN
    assign sel_step = sel_q - 4'd1;
`else
    assign sel_step = sel_q + 4'd1;
`endif

    // One-hot decode of which cap_word bit captures the mux sample this cycle.
    for (genvar gi = 0; gi < 16; gi++) begin : g_hit
        assign sel_hit[gi] = sample_en && (sel_q == 4'(gi));
    end

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        sel_d       = sel_q;
        hold_d      = hold_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        done_d      = 1'b0;
        cap_d       = cap_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    word_d  = bus.din;
                    sel_d   = FIRST_IDX;
                    hold_d  = 8'd0;
                    cap_d   = 16'd0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (sample_en) begin
                    hold_d      = 8'd0;
                    bit_out_d   = bus.mux_out;
                    bit_valid_d = 1'b1;
                    // The terminal index ends the scan; sel stays put rather than wrapping.
                    if (sel_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        sel_d = sel_step;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        for (int i = 0; i < 16; i++) begin
            if (sel_hit[i]) begin
                cap_d[i] = bus.mux_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            word_q      <= 16'd0;
            sel_q       <= FIRST_IDX;
            hold_q      <= 8'd0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
            cap_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            sel_q       <= sel_d;
            hold_q      <= hold_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            done_q      <= done_d;
            cap_q       <= cap_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.D         = word_q;
    assign bus.sel       = sel_q;
    assign bus.bit_out   = bit_out_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.done      = done_q;
    assign bus.cap_word  = cap_q;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench for mux_scan_serializer: HOLD_CYCLES=1 and =3 instances, each
// driving a behavioural 16:1 mux; scan direction follows SCAN_DIR_DOWN_EN.
module tb_mux_scan_serializer;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

`ifdef SCAN_DIR_DOWN_EN
    localparam bit DOWN = 1'b1;
`else
    localparam bit DOWN = 1'b0;
`endif

    mux_scan_serializer_if bus1();
    mux_scan_serializer_if bus3();

    // External 16:1 mux models.
    assign bus1.mux_out = bus1.D[bus1.sel];
    assign bus3.mux_out = bus3.D[bus3.sel];

    mux_scan_serializer #(.HOLD_CYCLES(1)) u_hold1 (.clk(clk), .rst(rst), .bus(bus1));
    mux_scan_serializer #(.HOLD_CYCLES(3)) u_hold3 (.clk(clk), .rst(rst), .bus(bus3));

    function automatic logic [3:0] idx(input int k);
        return DOWN ? 4'(15 - k) : 4'(k);
    endfunction

    task automatic check_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_bit({tag, "_ready"}, bus1.in_ready, 1'b1);
        check_word({tag, "_D"}, bus1.D, 16'h0000);
        check_word({tag, "_sel"}, 16'(bus1.sel), 16'(idx(0)));
        check_bit({tag, "_bv"}, bus1.bit_valid, 1'b0);
        check_bit({tag, "_bit"}, bus1.bit_out, 1'b0);
        check_bit({tag, "_done"}, bus1.done, 1'b0);
        check_word({tag, "_cap"}, bus1.cap_word, 16'h0000);
    endtask

    // Full scan on the HOLD_CYCLES=1 instance; must be entered with the DUT in IDLE.
    task automatic scan1(input logic [15:0] w);
        @(negedge clk);
        bus1.in_valid = 1'b1;
        bus1.din      = w;
        step();
        bus1.in_valid = 1'b0;
        bus1.din      = 16'h0000;
        check_word("s1_D", bus1.D, w);
        check_bit("s1_bv_first", bus1.bit_valid, 1'b0);
        check_bit("s1_ready_busy", bus1.in_ready, 1'b0);
        for (int k = 0; k < 16; k++) begin
            check_word("s1_sel", 16'(bus1.sel), 16'(idx(k)));
            step();
            check_bit("s1_bv", bus1.bit_valid, 1'b1);
            check_bit("s1_bit", bus1.bit_out, w[idx(k)]);
            check_bit("s1_done", bus1.done, k == 15);
            check_word("s1_D_stable", bus1.D, w);
        end
        check_word("s1_cap", bus1.cap_word, w);
        check_bit("s1_ready_done", bus1.in_ready, 1'b0);
        step();
        check_bit("s1_ready_back", bus1.in_ready, 1'b1);
        check_bit("s1_bv_off", bus1.bit_valid, 1'b0);
        check_bit("s1_done_off", bus1.done, 1'b0);
        check_word("s1_cap_held", bus1.cap_word, w);
        $display("scan HOLD=1 din=%h cap_word=%h", w, bus1.cap_word);
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] exp_d;
        logic        found;

        rst           = 1'b1;
        bus1.in_valid = 1'b0;
        bus1.din      = 16'h0000;
        bus3.in_valid = 1'b0;
        bus3.din      = 16'h0000;
        repeat (2) step();
        check_reset_state("rst_init");
        check_bit("rst_init_ready3", bus3.in_ready, 1'b1);
        check_word("rst_init_cap3", bus3.cap_word, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_bit("idle_ready", bus1.in_ready, 1'b1);

        scan1(16'hA5C3);
        scan1(16'h00FF);

        // HOLD_CYCLES=3: each index held three cycles, strobes three cycles apart.
        w = 16'h8001;
        @(negedge clk);
        bus3.in_valid = 1'b1;
        bus3.din      = w;
        step();
        bus3.in_valid = 1'b0;
        bus3.din      = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            for (int h = 0; h < 3; h++) begin
                check_word("s3_sel", 16'(bus3.sel), 16'(idx(k)));
                check_bit("s3_bv", bus3.bit_valid, (h == 0) && (k > 0));
                if ((h == 0) && (k > 0)) begin
                    check_bit("s3_bit", bus3.bit_out, w[idx(k - 1)]);
                end
                check_bit("s3_done_early", bus3.done, 1'b0);
                step();
            end
        end
        check_bit("s3_bv_last", bus3.bit_valid, 1'b1);
        check_bit("s3_bit_last", bus3.bit_out, w[idx(15)]);
        check_bit("s3_done", bus3.done, 1'b1);
        check_word("s3_cap", bus3.cap_word, w);
        step();
        check_bit("s3_ready_back", bus3.in_ready, 1'b1);
        check_bit("s3_done_off", bus3.done, 1'b0);
        $display("scan HOLD=3 din=%h cap_word=%h", w, bus3.cap_word);

        // Reset in the middle of a scan, once sel reaches 7.
        @(negedge clk);
        bus1.in_valid = 1'b1;
        bus1.din      = 16'hFFFF;
        step();
        bus1.in_valid = 1'b0;
        bus1.din      = 16'h0000;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (bus1.sel == 4'd7) found = 1'b1;
            else step();
        end
        check_bit("mid_sel7_reached", found, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        step();
        check_reset_state("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        step();
        check_bit("rst_mid_ready_after", bus1.in_ready, 1'b1);
        $display("reset mid-scan at sel=7 applied");
        scan1(16'h1234);

        // Reset wins over a simultaneous handshake.
        @(negedge clk);
        rst           = 1'b1;
        bus1.in_valid = 1'b1;
        bus1.din      = 16'hBEEF;
        step();
        check_bit("rst_hs_ready", bus1.in_ready, 1'b1);
        check_word("rst_hs_D", bus1.D, 16'h0000);
        @(negedge clk);
        rst           = 1'b0;
        bus1.in_valid = 1'b0;
        step();
        check_bit("rst_hs_idle", bus1.in_ready, 1'b1);
        check_word("rst_hs_D_after", bus1.D, 16'h0000);
        $display("reset with in_valid: din=BEEF not accepted, D=%h", bus1.D);

        // in_valid held high with din changing every cycle: accepts at edge 0 and 18.
        @(negedge clk);
        bus1.in_valid = 1'b1;
        bus1.din      = 16'h1000;
        for (int n = 0; n < 36; n++) begin
            step();
            exp_d = (n < 18) ? 16'h1000 : 16'h1012;
            check_word("str_D", bus1.D, exp_d);
            check_bit("str_ready", bus1.in_ready, (n == 17) || (n == 35));
            if ((n == 16) || (n == 34)) begin
                check_bit("str_done", bus1.done, 1'b1);
                check_word("str_cap", bus1.cap_word, exp_d);
                $display("stream scan din=%h cap_word=%h", exp_d, bus1.cap_word);
            end
            @(negedge clk);
            bus1.din = 16'h1000 + 16'(n + 1);
        end
        bus1.in_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_serializer.md
MUX_SCAN_SERIALIZER -- requirements
Module: mux_scan_serializer

Interface
REQ-001 Parameter: HOLD_CYCLES, default 1, number of clock cycles each sel value is held (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  parallel word available on din.
REQ-005 din  input  16  parallel word to scan.
REQ-006 in_ready  output  1  block can accept a word.
REQ-007 D  output  16  registered word, driven to the 16:1 mux data input.
REQ-008 sel  output  4  registered bit index, driven to the 16:1 mux select.
REQ-009 mux_out  input  1  combinational output of the 16:1 mux.
REQ-010 bit_out  output  1  sampled mux bit.
REQ-011 bit_valid  output  1  one-cycle strobe qualifying bit_out.
REQ-012 cap_word  output  16  reassembled word; bit k holds the sample taken with sel=k.
REQ-013 done  output  1  one-cycle strobe; scan complete, cap_word final.

Function
REQ-014 FSM states IDLE, SCAN, DONE; in_ready=1 only in IDLE.
REQ-015 Handshake: transfer occurs on an edge where in_valid=1 and in_ready=1; din is registered into D, sel loads the first index, the hold counter clears, and the state goes to SCAN.
REQ-016 in_valid while not in IDLE is ignored; no queuing.
REQ-017 D shall remain constant from the accepting edge until the next accepted transfer.
REQ-018 In SCAN, sel holds each index for exactly HOLD_CYCLES cycles, then advances by one (direction per REQ-027).
REQ-019 mux_out is sampled on the last edge of each hold period; on that edge bit_out<=mux_out, bit_valid<=1, cap_word[sel]<=mux_out; bit_valid is 0 on all other edges.
REQ-020 After the sample of the 16th index: state goes to DONE and done=1 in the same cycle as the final bit_valid; the next edge returns to IDLE.
REQ-021 Timing with HOLD_CYCLES=1 and transfer on edge T: sel=k during cycle T+1+k; bit_valid for index k during cycle T+2+k; done during cycle T+17; in_ready=1 again in cycle T+18.
REQ-022 Total transfer-to-done latency is 16*HOLD_CYCLES+1 cycles.
REQ-023 sel never wraps within a scan; the terminal index ends the scan and is not followed by a wrap value.
REQ-024 cap_word clears to 0 on each accepted transfer and is held after done until the next transfer.

Reset
REQ-025 When rst=1 on an edge, from any state including mid-SCAN: state=IDLE, D=0, sel=first index, hold counter=0, bit_out=0, bit_valid=0, done=0, cap_word=0.
REQ-026 rst has priority over a simultaneous handshake; a word presented during reset is not accepted, and in_ready=1 in the cycle after reset deasserts.

Configuration
REQ-027 Macro SCAN_DIR_DOWN_EN: when defined, the first index is 15 and sel decrements to 0; when undefined, the first index is 0 and sel increments to 15. cap_word bit mapping per REQ-012 is unchanged, so cap_word equals din in both builds with a correct mux.

Verification
REQ-028 HOLD=1, no macro, din=16'hA5C3 -> sel 0..15 on consecutive cycles; bit_out sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; done in cycle T+17; cap_word=16'hA5C3.
REQ-029 HOLD=3, din=16'h8001 -> each sel value held 3 cycles; 16 bit_valid strobes spaced 3 cycles apart; done 49 cycles after transfer; cap_word=16'h8001.
REQ-030 SCAN_DIR_DOWN_EN defined, din=16'h00FF -> sel 15..0; first eight bit_out=0, last eight=1; cap_word=16'h00FF.
REQ-031 rst=1 asserted during SCAN at sel=7 -> next cycle all outputs at reset values and in_ready=1 after release; the next word, 16'h1234, scans fully and gives cap_word=16'h1234.
REQ-032 in_valid held high continuously with din changing every cycle -> only words presented in IDLE are accepted; D is stable throughout each scan; back-to-back scans are separated by exactly one IDLE cycle.
REQ-033 Simultaneous rst=1 and in_valid=1 -> no transfer; state IDLE; D=0.
